// File: rtl/player_pkg.sv
// -----------------------------------------------------------------------------
// player_pkg
// Shared types and constants for the record player.
//   state_t      : playback FSM states (GAP exists only when PLAYER_GAP_EN
//                  is defined)
//   DEF_ASCII_W  : default key code width
//   DEF_LEN_W    : default record duration width (ticks)
//   REST_CODE    : key code presented while nothing is sounding
// -----------------------------------------------------------------------------
package player_pkg;

  localparam int DEF_ASCII_W = 7;
  localparam int DEF_LEN_W   = 32;
  localparam int REST_CODE   = 0;

`ifdef PLAYER_GAP_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    PLAY  = 2'd2,
    GAP   = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    PLAY  = 2'd2
  } state_t;
`endif

endpackage : player_pkg

// File: rtl/record_player_if.sv
// -----------------------------------------------------------------------------
// record_player_if
// Control, record-stream and note-output signals of the record player.
//   master : sequencer/upstream side (drives start, stop, record stream;
//            observes ready, note and status outputs)
//   slave  : the player itself
// Signals:
//   start, stop            one-cycle control requests
//   rec_valid/rec_ready    record handshake; rec_ascii, rec_len, rec_last payload
//   note_ascii/note_active currently sounding key (0 = rest)
//   busy, done, err_zero_len status
// -----------------------------------------------------------------------------
interface record_player_if
  import player_pkg::*;
#(
  parameter int ASCII_W = DEF_ASCII_W,
  parameter int LEN_W   = DEF_LEN_W
) ();

  logic               start;
  logic               stop;
  logic               rec_valid;
  logic               rec_ready;
  logic [ASCII_W-1:0] rec_ascii;
  logic [LEN_W-1:0]   rec_len;
  logic               rec_last;
  logic [ASCII_W-1:0] note_ascii;
  logic               note_active;
  logic               busy;
  logic               done;
  logic               err_zero_len;

  modport master (
    output start, stop, rec_valid, rec_ascii, rec_len, rec_last,
    input  rec_ready, note_ascii, note_active, busy, done, err_zero_len
  );

  modport slave (
    input  start, stop, rec_valid, rec_ascii, rec_len, rec_last,
    output rec_ready, note_ascii, note_active, busy, done, err_zero_len
  );

endinterface : record_player_if

// File: rtl/tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Free-running divider producing a one-cycle tick every TICK_DIV clocks.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   clear : restart the count; the cycle after clear is phase 0
//   tick  : high on the last cycle of each TICK_DIV period
// -----------------------------------------------------------------------------
module tick_prescaler #(
  parameter int TICK_DIV = 4   // 1..65535
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  // With TICK_DIV = 1 the counter sits at 0 and tick is permanently high.
  assign tick = (r_cnt == LAST_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clear || tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule : tick_prescaler

// File: rtl/record_player.sv
// -----------------------------------------------------------------------------
// record_player
// Plays a stream of (key, duration, last) records: each record sounds its key
// for rec_len ticks of TICK_DIV clocks, then the next record is fetched.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : record_player_if.slave (control, record stream, note/status out)
// Build option:
//   PLAYER_GAP_EN : when defined, a one-tick rest (GAP state) is inserted
//                   between consecutive non-last notes.
// -----------------------------------------------------------------------------
module record_player
  import player_pkg::*;
#(
  parameter int ASCII_W  = DEF_ASCII_W,
  parameter int LEN_W    = DEF_LEN_W,
  parameter int TICK_DIV = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  record_player_if.slave  bus
);

  state_t             r_state;
  state_t             w_state_next;
  logic [ASCII_W-1:0] r_ascii;
  logic [LEN_W-1:0]   r_rem;
  logic               r_last;
  logic               r_done;
  logic               r_err;

  logic w_tick;
  logic w_clear;
  logic w_xfer;
  logic w_zero;
  logic w_note_end;
  logic w_start_ok;
  logic w_done_next;

  // Restarting the prescaler on every state change makes PLAY (and GAP)
  // always begin at phase 0, so a note lasts exactly rec_len*TICK_DIV cycles.
  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (w_clear),
    .tick  (w_tick)
  );

  assign w_xfer     = (r_state == FETCH) && bus.rec_valid;
  assign w_zero     = (bus.rec_len == '0);
  assign w_note_end = (r_state == PLAY) && w_tick && (r_rem == LEN_W'(1));
  assign w_start_ok = (r_state == IDLE) && bus.start && !bus.stop;
  assign w_clear    = (w_state_next != r_state);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and done request
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_done_next  = 1'b0;
    if (bus.stop) begin
      // Abort wins over everything, including a same-cycle transfer.
      w_state_next = IDLE;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.start) begin
            w_state_next = FETCH;
          end
        end
        FETCH: begin
          if (w_xfer) begin
            if (!w_zero) begin
              w_state_next = PLAY;
            end else if (bus.rec_last) begin
              w_state_next = IDLE;
              w_done_next  = 1'b1;
            end
          end
        end
        PLAY: begin
          if (w_note_end) begin
            if (r_last) begin
              w_state_next = IDLE;
              w_done_next  = 1'b1;
            end else begin
`ifdef PLAYER_GAP_EN
              w_state_next = GAP;
`else
              w_state_next = FETCH;
`endif
            end
          end
        end
`ifdef PLAYER_GAP_EN
        GAP: begin
          if (w_tick) begin
            w_state_next = FETCH;
          end
        end
`endif
        default: begin
          w_state_next = IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Record hold, remaining-tick counter, status flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ascii <= '0;
      r_rem   <= '0;
      r_last  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= w_done_next;

      if (w_xfer && !bus.stop && !w_zero) begin
        r_ascii <= bus.rec_ascii;
        r_rem   <= bus.rec_len;
        r_last  <= bus.rec_last;
      end else if ((r_state == PLAY) && w_tick) begin
        r_rem <= r_rem - LEN_W'(1);
      end

      // A record discarded by a same-cycle stop leaves no trace, not even
      // the zero-length flag.
      if (w_start_ok) begin
        r_err <= 1'b0;
      end else if (w_xfer && !bus.stop && w_zero) begin
        r_err <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (decoded from registered state, so reset forces them at once)
  // ---------------------------------------------------------------------------
  assign bus.rec_ready    = (r_state == FETCH);
  assign bus.busy         = (r_state != IDLE);
  assign bus.note_active  = (r_state == PLAY);
  assign bus.note_ascii   = (r_state == PLAY) ? r_ascii : ASCII_W'(REST_CODE);
  assign bus.done         = r_done;
  assign bus.err_zero_len = r_err;

endmodule : record_player

// File: tb/tb_record_player.sv
// -----------------------------------------------------------------------------
// tb_record_player
// Directed bench for record_player with TICK_DIV = 4. Build with or without
// PLAYER_GAP_EN; the expected inter-note rest adapts to the macro.
// -----------------------------------------------------------------------------
module tb_record_player;

  localparam int TD = 4;
`ifdef PLAYER_GAP_EN
  localparam int REST_CYC = TD + 1;
`else
  localparam int REST_CYC = 1;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  record_player_if #(.ASCII_W(7), .LEN_W(32)) bus ();

  record_player #(
    .ASCII_W  (7),
    .LEN_W    (32),
    .TICK_DIV (TD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_rec(input int a, input int l, input bit last, input bit v);
    bus.rec_ascii = 7'(a);
    bus.rec_len   = 32'(l);
    bus.rec_last  = last;
    bus.rec_valid = v;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    set_rec(0, 0, 1'b0, 1'b0);

    // Reset state
    #2;
    chk("rst_busy",   32'(bus.busy), 0);
    chk("rst_ready",  32'(bus.rec_ready), 0);
    chk("rst_note",   32'(bus.note_ascii), 0);
    chk("rst_active", 32'(bus.note_active), 0);
    chk("rst_done",   32'(bus.done), 0);
    chk("rst_err",    32'(bus.err_zero_len), 0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Single record 97 len 3 last: 12 note cycles then done with rest
    set_rec(97, 3, 1'b1, 1'b1);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("t1_ready", 32'(bus.rec_ready), 1);
    chk("t1_busy",  32'(bus.busy), 1);
    chk("t1_fetch_rest", 32'(bus.note_active), 0);
    step();
    bus.rec_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk("t1_note",   32'(bus.note_ascii), 97);
      chk("t1_active", 32'(bus.note_active), 1);
      chk("t1_nodone", 32'(bus.done), 0);
      bus.start = (i == 5);  // start during PLAY must be ignored
      step();
    end
    bus.start = 1'b0;
    chk("t1_end_note", 32'(bus.note_ascii), 0);
    chk("t1_end_done", 32'(bus.done), 1);
    chk("t1_end_busy", 32'(bus.busy), 0);
    step();
    chk("t1_done_pulse", 32'(bus.done), 0);
    chk("t1_idle", 32'(bus.busy), 0);

    // Two records, valid held: 97x8, rest, 98x4
    set_rec(97, 2, 1'b0, 1'b1);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    set_rec(98, 1, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      chk("t2_note97", 32'(bus.note_ascii), 97);
      step();
    end
    for (int i = 0; i < REST_CYC; i++) begin
      chk("t2_rest_note", 32'(bus.note_ascii), 0);
      chk("t2_rest_act",  32'(bus.note_active), 0);
      chk("t2_rest_busy", 32'(bus.busy), 1);
      chk("t2_rest_done", 32'(bus.done), 0);
      step();
    end
    bus.rec_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t2_note98", 32'(bus.note_ascii), 98);
      step();
    end
    chk("t2_done", 32'(bus.done), 1);
    chk("t2_end_note", 32'(bus.note_ascii), 0);
    step();

    // Zero-length last record
    set_rec(99, 0, 1'b1, 1'b1);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("t3_ready", 32'(bus.rec_ready), 1);
    chk("t3_err_pre", 32'(bus.err_zero_len), 0);
    step();
    bus.rec_valid = 1'b0;
    chk("t3_err",    32'(bus.err_zero_len), 1);
    chk("t3_done",   32'(bus.done), 1);
    chk("t3_busy",   32'(bus.busy), 0);
    chk("t3_active", 32'(bus.note_active), 0);
    step();
    chk("t3_err_sticky", 32'(bus.err_zero_len), 1);
    chk("t3_done_pulse", 32'(bus.done), 0);

    // Stop on cycle 5 of a long note; accepted start clears the error flag
    set_rec(97, 10, 1'b1, 1'b1);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("t4_err_clear", 32'(bus.err_zero_len), 0);
    step();
    bus.rec_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t4_note", 32'(bus.note_ascii), 97);
      step();
    end
    chk("t4_note5", 32'(bus.note_ascii), 97);
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    chk("t4_stop_note", 32'(bus.note_ascii), 0);
    chk("t4_stop_busy", 32'(bus.busy), 0);
    chk("t4_stop_done", 32'(bus.done), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_no_done", 32'(bus.done), 0);
      chk("t4_idle",    32'(bus.busy), 0);
    end

    // start and stop together in IDLE
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    step();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    chk("t5_busy",  32'(bus.busy), 0);
    chk("t5_ready", 32'(bus.rec_ready), 0);
    set_rec(97, 3, 1'b1, 1'b1);
    step();
    chk("t5_ready2", 32'(bus.rec_ready), 0);
    chk("t5_busy2",  32'(bus.busy), 0);
    bus.rec_valid = 1'b0;

    // Transfer and stop in the same cycle: record discarded
    set_rec(100, 5, 1'b1, 1'b1);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("t6_ready", 32'(bus.rec_ready), 1);
    bus.stop = 1'b1;
    step();
    bus.stop      = 1'b0;
    bus.rec_valid = 1'b0;
    chk("t6_busy",   32'(bus.busy), 0);
    chk("t6_active", 32'(bus.note_active), 0);
    chk("t6_done",   32'(bus.done), 0);
    step();
    chk("t6_active2", 32'(bus.note_active), 0);
    chk("t6_busy2",   32'(bus.busy), 0);

    // Reset mid-PLAY, then replay
    set_rec(97, 3, 1'b1, 1'b1);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    bus.rec_valid = 1'b0;
    step();
    step();
    chk("t7_playing", 32'(bus.note_ascii), 97);
    rst_n = 1'b0;
    #1;
    chk("t7_rst_note",   32'(bus.note_ascii), 0);
    chk("t7_rst_active", 32'(bus.note_active), 0);
    chk("t7_rst_busy",   32'(bus.busy), 0);
    chk("t7_rst_ready",  32'(bus.rec_ready), 0);
    chk("t7_rst_done",   32'(bus.done), 0);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("t7_post_done", 32'(bus.done), 0);
      chk("t7_post_busy", 32'(bus.busy), 0);
      step();
    end
    set_rec(98, 1, 1'b1, 1'b1);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    bus.rec_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t7_replay", 32'(bus.note_ascii), 98);
      step();
    end
    chk("t7_replay_done", 32'(bus.done), 1);
    chk("t7_replay_rest", 32'(bus.note_ascii), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_record_player

// File: doc/record_player.md
RECORD_PLAYER -- requirements
Module: record_player

Interface
REQ-001 Parameter ASCII_W, default 7, key code width.
REQ-002 Parameter LEN_W, default 32, record duration width in ticks.
REQ-003 Parameter TICK_DIV, default 4, clk cycles per playback tick; range 1..65535.
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 start  in  1  one-cycle request to begin playback.
REQ-007 stop  in  1  one-cycle abort request.
REQ-008 rec_valid  in  1  upstream record available.
REQ-009 rec_ready  out  1  player accepts record this cycle.
REQ-010 rec_ascii  in  ASCII_W  record key code.
REQ-011 rec_len  in  LEN_W  record duration in ticks.
REQ-012 rec_last  in  1  record is final of the recording.
REQ-013 note_ascii  out  ASCII_W  key currently sounding; 0 = rest.
REQ-014 note_active  out  1  high while note_ascii is a played note.
REQ-015 busy  out  1  high in any state other than IDLE.
REQ-016 done  out  1  one-cycle pulse on normal completion.
REQ-017 err_zero_len  out  1  sticky flag, zero-length record seen.

Function
REQ-018 FSM states: IDLE, FETCH, PLAY, GAP (macro only); next state registered.
REQ-019 IDLE: start=1 and stop=0 -> FETCH next cycle; start ignored in every other state.
REQ-020 rec_ready = 1 exactly in FETCH; transfer on rec_valid & rec_ready.
REQ-021 On transfer with rec_len != 0: capture ascii, len, last; next cycle PLAY with note_ascii = captured code, note_active = 1.
REQ-022 On transfer with rec_len == 0: set err_zero_len; no note; go IDLE with done pulse if rec_last, else stay FETCH.
REQ-023 Prescaler cleared on PLAY entry; tick pulses every TICK_DIV cycles; PLAY lasts exactly rec_len*TICK_DIV cycles.
REQ-024 Remaining count decrements on tick; tick with remaining == 1 ends the note.
REQ-025 Note end: rec_last=1 -> IDLE with done=1 that cycle; else FETCH (or GAP with macro).
REQ-026 Outside PLAY, note_ascii = 0 and note_active = 0.
REQ-027 stop=1 in any state -> IDLE next cycle, no done pulse, outputs to rest; stop beats start in same cycle.
REQ-028 Transfer and stop in same cycle: record consumed and discarded.
REQ-029 rec_len = all-ones plays full duration, no wrap.
REQ-030 err_zero_len clears only on reset or on start accepted in IDLE.

Reset
REQ-031 rst_n low: state IDLE, note_ascii 0, note_active 0, rec_ready 0, busy 0, done 0, err_zero_len 0, counters 0, immediately.
REQ-032 Reset mid-PLAY abandons held record; no done pulse after release.

Configuration
REQ-033 PLAYER_GAP_EN defined: between non-last notes, GAP state holds rest for exactly one tick (TICK_DIV cycles), then FETCH.
REQ-034 PLAYER_GAP_EN undefined: no GAP state; PLAY goes directly to FETCH.

Structure
REQ-035 Package player_pkg holds state enum, default ASCII_W/LEN_W, REST_CODE = 0.
REQ-036 Sub-module tick_prescaler (clk, rst_n, clear, tick) produces the tick pulse.

Verification (TICK_DIV=4)
REQ-037 Single record (97, len 3, last) after start -> note_ascii=97 for 12 cycles, then 0 and done pulse same cycle as end.
REQ-038 Records (97,2),(98,1,last), rec_valid held -> 97 for 8 cycles, 1 rest cycle, 98 for 4 cycles; with PLAYER_GAP_EN rest is 5 cycles.
REQ-039 Record (99, len 0, last) -> err_zero_len=1, no note_active, done pulse, busy low next cycle.
REQ-040 stop on cycle 5 of (97, len 10) -> note_ascii=0, busy=0 next cycle, no done pulse.
REQ-041 start and stop same cycle in IDLE -> stays IDLE, rec_ready never asserted.
REQ-042 rst_n low mid-PLAY -> all outputs zero asynchronously; after release, start replays normally.
